// File: rtl/neuron_sweep_ctrl.sv
// neuron_sweep_ctrl: drives a 2-input McCulloch-Pitts neuron through every
// x/y combination for one threshold (or all four), samples fire after a
// programmable settle time, builds truth tables and classifies the gate.
module neuron_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 1,
    parameter int TH_W          = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            sweep_all,
    input  logic [TH_W-1:0] th_sel,
    output logic            x,
    output logic            y,
    output logic [TH_W-1:0] Threshold,
    input  logic            fire,
    output logic            busy,
    output logic            done,
    output logic [3:0]      truth,
    output logic [15:0]     tt_all,
    output logic [2:0]      gate_id
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

    localparam logic [2:0] GID_ZERO  = 3'd0;
    localparam logic [2:0] GID_AND   = 3'd1;
    localparam logic [2:0] GID_OR    = 3'd2;
    localparam logic [2:0] GID_ONE   = 3'd3;
    localparam logic [2:0] GID_XOR   = 3'd4;
    localparam logic [2:0] GID_OTHER = 3'd7;

    state_t          state_q, state_d;
    logic            sweep_q, sweep_d;
    logic [TH_W-1:0] sel_q, sel_d;
    logic [1:0]      k_q, k_d;
    logic [TH_W-1:0] t_q, t_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            x_q, x_d;
    logic            y_q, y_d;
    logic [TH_W-1:0] th_q, th_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [3:0]      truth_q, truth_d;
    logic [15:0]     tt_q, tt_d;
    logic [2:0]      gid_q, gid_d;

    // Working signals for the sample edge
    logic            last_combo;
    logic [1:0]      k_nxt;
    logic [TH_W-1:0] t_nxt;
    logic [3:0]      tt_idx;

    // Map a 4-entry truth table (bit k = fire for x=k[1], y=k[0]) to a gate code
    function automatic logic [2:0] classify(input logic [3:0] tt);
        logic [2:0] code;
        case (tt)
            4'b0000: code = GID_ZERO;
            4'b1000: code = GID_AND;
            4'b1110: code = GID_OR;
            4'b1111: code = GID_ONE;
            4'b0110: code = GID_XOR;
            default: code = GID_OTHER;
        endcase
        return code;
    endfunction

    // State and output registers; reset aborts any run without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sweep_q <= 1'b0;
            sel_q   <= '0;
            k_q     <= 2'd0;
            t_q     <= '0;
            cnt_q   <= 4'd0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            th_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            truth_q <= 4'd0;
            tt_q    <= 16'd0;
            gid_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            sel_q   <= sel_d;
            k_q     <= k_d;
            t_q     <= t_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            th_q    <= th_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            truth_q <= truth_d;
            tt_q    <= tt_d;
            gid_q   <= gid_d;
        end
    end

    // Next-state logic: accept start, step through combos, finalise results
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        sel_d   = sel_q;
        k_d     = k_q;
        t_d     = t_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        th_d    = th_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        truth_d = truth_q;
        tt_d    = tt_q;
        gid_d   = gid_q;

        // Terminal test is explicit so the threshold counter may wrap freely
        last_combo = (k_q == 2'd3) && (!sweep_q || (t_q == TH_W'(3)));
        k_nxt      = k_q + 2'd1;
        t_nxt      = (k_q == 2'd3) ? (t_q + TH_W'(1)) : t_q;
        tt_idx     = {t_q, k_q};

        case (state_q)
            S_IDLE: begin
                x_d    = 1'b0;
                y_d    = 1'b0;
                th_d   = '0;
                busy_d = 1'b0;
                if (start) begin
                    sweep_d = sweep_all;
                    sel_d   = th_sel;
                    tt_d    = 16'd0;
                    truth_d = 4'd0;
                    gid_d   = 3'd0;
                    k_d     = 2'd0;
                    cnt_d   = 4'd0;
                    t_d     = sweep_all ? '0 : th_sel;
                    th_d    = sweep_all ? '0 : th_sel;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (cnt_q == SETTLE_LAST) begin
                    // Last edge of the hold window: capture fire, move on
                    tt_d[tt_idx] = fire;
                    cnt_d        = 4'd0;
                    if (last_combo) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        truth_d = tt_d[{sel_q, 2'b00} +: 4];
                        gid_d   = classify(tt_d[{sel_q, 2'b00} +: 4]);
                        x_d     = 1'b0;
                        y_d     = 1'b0;
                        th_d    = '0;
                    end else begin
                        k_d  = k_nxt;
                        t_d  = t_nxt;
                        x_d  = k_nxt[1];
                        y_d  = k_nxt[0];
                        th_d = t_nxt;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign x         = x_q;
    assign y         = y_q;
    assign Threshold = th_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign truth     = truth_q;
    assign tt_all    = tt_q;
    assign gate_id   = gid_q;

endmodule

// File: tb/tb_neuron_sweep_ctrl.sv
// Directed bench for neuron_sweep_ctrl with a behavioural neuronode
// (fire = x + y >= Threshold) and alternative forced fire functions.
module tb_neuron_sweep_ctrl;

    localparam int S = 1;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sweep_all;
    logic [1:0]  th_sel;
    logic        x;
    logic        y;
    logic [1:0]  Threshold;
    logic        fire;
    logic        busy;
    logic        done;
    logic [3:0]  truth;
    logic [15:0] tt_all;
    logic [2:0]  gate_id;

    int checks = 0;
    int errors = 0;
    int mode   = 0;

    neuron_sweep_ctrl #(.SETTLE_CYCLES(S), .TH_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sweep_all(sweep_all),
        .th_sel(th_sel), .x(x), .y(y), .Threshold(Threshold), .fire(fire),
        .busy(busy), .done(done), .truth(truth), .tt_all(tt_all),
        .gate_id(gate_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Neuron model: 0 = neuronode, 1 = x XOR y, 2 = x only
    always_comb begin
        logic [1:0] sum;
        sum = {1'b0, x} + {1'b0, y};
        case (mode)
            1:       fire = x ^ y;
            2:       fire = x;
            default: fire = (sum >= Threshold);
        endcase
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One run from the start pulse to the cycle after done
    task automatic do_run(input string tag, input bit sw, input logic [1:0] sel,
                          input bit mid_pulse, input logic [3:0] etruth,
                          input logic [15:0] ett, input logic [2:0] egid);
        int n;
        int cycles;
        int combo;
        logic [1:0] ek;
        logic [1:0] et;
        n = sw ? 16 : 4;
        @(negedge clk);
        start = 1'b1; sweep_all = sw; th_sel = sel;
        @(negedge clk);
        start = 1'b0; th_sel = ~sel; sweep_all = ~sw;
        check({tag, " busy_rise"}, {15'd0, busy}, 16'd1);
        cycles = 0;
        while (cycles < 100) begin
            if (!busy) break;
            combo = cycles / (S + 1);
            ek = 2'(combo % 4);
            et = sw ? 2'(combo / 4) : sel;
            check({tag, " drive"}, {12'd0, x, y, Threshold}, {12'd0, ek[1], ek[0], et});
            start = (mid_pulse && (cycles == 3 || cycles == 6)) ? 1'b1 : 1'b0;
            cycles++;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " busy_cycles"}, 16'(cycles), 16'(n * (S + 1)));
        check({tag, " done"}, {15'd0, done}, 16'd1);
        check({tag, " truth"}, {12'd0, truth}, {12'd0, etruth});
        check({tag, " tt_all"}, tt_all, ett);
        check({tag, " gate_id"}, {13'd0, gate_id}, {13'd0, egid});
        check({tag, " idle_drive"}, {12'd0, x, y, Threshold}, 16'd0);
        @(negedge clk);
        check({tag, " done_pulse"}, {15'd0, done}, 16'd0);
        check({tag, " hold_tt"}, tt_all, ett);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; start = 1'b0; sweep_all = 1'b0; th_sel = 2'd0;
        repeat (3) @(negedge clk);
        check("rst outputs", {x, y, Threshold, busy, done, truth, gate_id},
              {2'b00, 2'd0, 1'b0, 1'b0, 4'd0, 3'd0});
        check("rst tt_all", tt_all, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        mode = 0;
        do_run("single th2", 1'b0, 2'd2, 1'b0, 4'b1000, 16'h0800, 3'd1);
        do_run("single th1", 1'b0, 2'd1, 1'b0, 4'b1110, 16'h00E0, 3'd2);
        do_run("sweep sel0", 1'b1, 2'd0, 1'b0, 4'b1111, 16'h08EF, 3'd3);
        do_run("sweep sel3", 1'b1, 2'd3, 1'b0, 4'b0000, 16'h08EF, 3'd0);
        mode = 1;
        do_run("xor th0", 1'b0, 2'd0, 1'b0, 4'b0110, 16'h0006, 3'd4);
        mode = 2;
        do_run("xonly th2", 1'b0, 2'd2, 1'b0, 4'b1100, 16'h0C00, 3'd7);
        mode = 0;
        do_run("mid pulse", 1'b0, 2'd2, 1'b1, 4'b1000, 16'h0800, 3'd1);

        // start held high: back-to-back runs with one IDLE cycle in between
        start = 1'b1; sweep_all = 1'b0; th_sel = 2'd2;
        @(negedge clk);
        check("held busy1", {15'd0, busy}, 16'd1);
        cnt = 0;
        while (busy && cnt < 100) begin cnt++; @(negedge clk); end
        check("held cycles", 16'(cnt), 16'(4 * (S + 1)));
        check("held done", {15'd0, done}, 16'd1);
        @(negedge clk);
        check("held idle", {14'd0, busy, done}, 16'd0);
        @(negedge clk);
        check("held busy2", {15'd0, busy}, 16'd1);
        start = 1'b0;
        cnt = 0;
        while (!done && cnt < 100) begin cnt++; @(negedge clk); end
        check("held run2 done", {15'd0, done}, 16'd1);
        check("held run2 tt", tt_all, 16'h0800);
        @(negedge clk);

        // Reset mid-sweep while combo 7 (t=1, k=3) is being driven
        @(negedge clk);
        start = 1'b1; sweep_all = 1'b1; th_sel = 2'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        check("pre-rst combo7", {13'd0, busy, x, y, Threshold}, {13'd0, 1'b1, 1'b1, 1'b1, 2'd1});
        rst_n = 1'b0;
        #1;
        check("rst mid outputs", {x, y, Threshold, busy, done, truth, gate_id},
              {2'b00, 2'd0, 1'b0, 1'b0, 4'd0, 3'd0});
        check("rst mid tt_all", tt_all, 16'd0);
        repeat (2) @(negedge clk);
        check("rst no done", {14'd0, busy, done}, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst idle", {14'd0, busy, done}, 16'd0);
        do_run("sweep after rst", 1'b1, 2'd0, 1'b0, 4'b1111, 16'h08EF, 3'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/neuron_sweep_ctrl.md
Name: neuron_sweep_ctrl

Overview:
- Sequential stimulus and capture stage that sits directly upstream of neuronode, a combinational McCulloch-Pitts 2-input neuron.
- Drives the neuron's x, y and Threshold inputs through every input combination for one threshold, or for all four thresholds.
- Samples fire after a programmable settle time and builds truth tables.
- Classifies the result as a logic gate, making the neuron self-characterising in hardware.

Parameters:
- SETTLE_CYCLES, 1, idle cycles each combination is held before fire is sampled (legal range 0..15).
- TH_W, 2, Threshold width; fixed at 2 for neuronode.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request a run; accepted only in IDLE.
- sweep_all  input  1  sampled with start: 1 = thresholds 0..3, 0 = th_sel only.
- th_sel  input  2  sampled with start: threshold for single run; also selects which nibble drives truth/gate_id.
- x  output  1  neuron input x (registered).
- y  output  1  neuron input y (registered).
- Threshold  output  2  neuron threshold (registered).
- fire  input  1  neuron output, sampled.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse when results are final.
- truth  output  4  truth table for the latched th_sel; bit k = fire for x=k[1], y=k[0].
- tt_all  output  16  tt_all[4t+3:4t] = truth table for threshold t.
- gate_id  output  3  classification of truth.

Behaviour:
- Reset (rst_n low, any time, including mid-run): state IDLE; abort with no done pulse. Reset values: x=0, y=0, Threshold=0, busy=0, done=0, truth=0, tt_all=0, gate_id=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - x=y=0, Threshold=0.
  - start=1 at edge E0: latch sweep_all and th_sel, clear tt_all, truth and gate_id to 0.
  - Load combo k=0 and threshold t (t = 0 if sweep_all, else th_sel). Go to RUN; busy=1 from E0.
- RUN:
  - Each combination holds x=k[1], y=k[0], Threshold=t for SETTLE_CYCLES+1 cycles.
  - At the last edge of that window, store fire into tt_all[4t+k] and advance k.
  - k wraps 3 to 0 with t+1 when sweep_all=1. The run ends after k=3 of t=3 (sweep) or after k=3 (single).
  - 4 combos (single) or 16 combos (sweep); no gaps between combos.
  - Last sample edge EL = E0 + N*(SETTLE_CYCLES+1), where N = 4 or 16.
- At EL:
  - Go to DONE.
  - busy=0, done=1 for exactly one cycle.
  - truth = tt_all nibble for the latched th_sel, including the final sample.
  - gate_id updated in the same cycle.
  - x, y and Threshold return to 0.
- DONE: unconditional return to IDLE next edge; start is ignored in DONE and in RUN (no queuing).
- Results (truth, tt_all, gate_id) hold until the next accepted start or reset.
- gate_id encoding by truth:
  - 0000 -> 0 ZERO
  - 1000 -> 1 AND
  - 1110 -> 2 OR
  - 1111 -> 3 ONE
  - 0110 -> 4 XOR
  - all others -> 7 OTHER
  - Codes 5 and 6 are reserved.
- fire is treated as synchronous to clk; it is never sampled outside the sample edge.
- Counters:
  - settle counter width 4.
  - combo index width 2.
  - threshold index width 2; it wraps naturally, and the terminal condition is explicit rather than wrap-based.

Test Plan:
- Single, th_sel=2, SETTLE_CYCLES=1, neuronode attached: start pulse at E0 -> busy high 8 cycles; x/y step 00,01,10,11 every 2 cycles with Threshold=2; done pulse at E0+8; truth=1000, gate_id=1, tt_all=16'h0800.
- Single, th_sel=1 -> truth=1110, gate_id=2, tt_all=16'h00E0.
- Sweep_all=1, th_sel=0, SETTLE_CYCLES=1 -> 32 busy cycles; tt_all=16'h08EF; truth=1111, gate_id=3. Repeat with th_sel=3 -> truth=0000, gate_id=0, same tt_all.
- Bench model forcing fire = x XOR y, single run -> truth=0110, gate_id=4. Forcing fire = x only -> truth=1100, gate_id=7.
- start held high continuously -> runs back-to-back with exactly one IDLE cycle between them (done cycle, then start accepted in IDLE); start pulses during RUN are ignored and timing is unchanged.
- rst_n dropped mid-sweep at combo 7 -> all outputs 0 immediately, with no done. After release, a new start runs a full sweep producing tt_all=16'h08EF.
